// File: rtl/rf_writeback_arbiter_pkg.sv
// Shared widths and buffer entry layout for the register-file writeback path.
package rf_writeback_arbiter_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/rf_writeback_arbiter_wb_fifo.sv
// Small synchronous FIFO holding long-latency results awaiting a writeback slot.
module wb_fifo
    import rf_writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  wb_entry_t                din,
    output wb_entry_t                dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    wb_entry_t     mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    // Push is refused when full even if a pop frees a slot in the same cycle.
    assign do_push = push && (count != CNT_FULL);
    assign do_pop  = pop && (count != '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Single regfile write port: pipeline writeback first, buffered long-latency results otherwise.
module rf_writeback_arbiter
    import rf_writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pipe_we,
    input  logic [REG_AW-1:0]      pipe_rd,
    input  logic [XLEN-1:0]        pipe_wd,
    input  logic                   lu_issue,
    input  logic [REG_AW-1:0]      lu_issue_rd,
    input  logic                   lu_valid,
    input  logic [REG_AW-1:0]      lu_rd,
    input  logic [XLEN-1:0]        lu_data,
    output logic                   lu_ready,
    input  logic [REG_AW-1:0]      chk_rs1,
    input  logic [REG_AW-1:0]      chk_rs2,
    input  logic [REG_AW-1:0]      chk_rd,
    output logic                   hazard,
    output logic                   we3,
    output logic [REG_AW-1:0]      a3,
    output logic [XLEN-1:0]        wd3,
    output logic [31:0]            busy,
    output logic [$clog2(DEPTH):0] lu_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

    wb_entry_t fifo_din;
    wb_entry_t head;
    logic      pipe_sel;
    logic      fifo_push;
    logic      fifo_pop;
    logic [31:0] busy_next;

    assign lu_ready  = (lu_count != CNT_FULL);
    assign pipe_sel  = pipe_we && (pipe_rd != '0);
    // x0 results complete the handshake but are never stored.
    assign fifo_push = lu_valid && lu_ready && (lu_rd != '0);
    assign fifo_pop  = !pipe_sel && (lu_count != '0);
    assign fifo_din  = '{rd: lu_rd, data: lu_data};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (head),
        .count (lu_count)
    );

    // Clear applied before set so a same-cycle issue to the popped register stays busy.
    always_comb begin
        busy_next = busy;
        if (fifo_pop) busy_next[head.rd] = 1'b0;
        if (lu_issue && (lu_issue_rd != '0)) busy_next[lu_issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    assign hazard = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
            we3  <= 1'b0;
            a3   <= '0;
            wd3  <= '0;
        end else begin
            busy <= busy_next;
            if (pipe_sel) begin
                we3 <= 1'b1;
                a3  <= pipe_rd;
                wd3 <= pipe_wd;
            end else if (fifo_pop) begin
                we3 <= 1'b1;
                a3  <= head.rd;
                wd3 <= head.data;
            end else begin
                we3 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Self-checking bench for rf_writeback_arbiter against a queue-based reference model.
module tb_rf_writeback_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_wd;
    logic        lu_issue;
    logic [4:0]  lu_issue_rd;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic [4:0]  chk_rs1, chk_rs2, chk_rd;
    logic        hazard;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [31:0] busy;
    logic [1:0]  lu_count;

    rf_writeback_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd),
        .lu_issue(lu_issue), .lu_issue_rd(lu_issue_rd),
        .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd), .hazard(hazard),
        .we3(we3), .a3(a3), .wd3(wd3), .busy(busy), .lu_count(lu_count)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    // Reference model state
    int          q_rd[$];
    logic [31:0] q_wd[$];
    logic [31:0] m_busy;
    logic        m_we;
    logic [4:0]  m_a;
    logic [31:0] m_wd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_hazard();
        return m_busy[chk_rs1] | m_busy[chk_rs2] | m_busy[chk_rd];
    endfunction

    task automatic model_reset();
        q_rd.delete();
        q_wd.delete();
        m_busy = '0;
        m_we = 1'b0;
        m_a = '0;
        m_wd = '0;
    endtask

    task automatic model_edge();
        logic        ready;
        logic [31:0] nb;
        int          hrd;
        ready = (q_rd.size() < DEPTH);
        nb = m_busy;
        if (pipe_we && pipe_rd != 0) begin
            m_we = 1'b1; m_a = pipe_rd; m_wd = pipe_wd;
        end else if (q_rd.size() > 0) begin
            hrd = q_rd.pop_front();
            m_wd = q_wd.pop_front();
            m_a = 5'(hrd);
            m_we = 1'b1;
            nb[hrd] = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        if (lu_issue && lu_issue_rd != 0) nb[lu_issue_rd] = 1'b1;
        if (lu_valid && ready && lu_rd != 0) begin
            q_rd.push_back(int'(lu_rd));
            q_wd.push_back(lu_data);
        end
        m_busy = nb;
    endtask

    task automatic check_outputs();
        chk("we3", we3, m_we);
        chk("a3", a3, m_a);
        chk("wd3", wd3, m_wd);
        chk("busy", busy, m_busy);
        chk("lu_count", lu_count, q_rd.size());
    endtask

    task automatic step();
        #1;
        chk("hazard", hazard, model_hazard());
        chk("lu_ready", lu_ready, q_rd.size() < DEPTH);
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        pipe_we = 0; pipe_rd = 0; pipe_wd = 0;
        lu_issue = 0; lu_issue_rd = 0;
        lu_valid = 0; lu_rd = 0; lu_data = 0;
        chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
    endtask

    initial begin
        int          idx;
        int          rds[3];
        logic [31:0] dats[3];
        int          got_rd[$];
        logic [31:0] got_wd[$];
        logic [31:0] busy_before;
        logic        rdy;

        idle_inputs();
        rst = 1'b1;
        model_reset();
        #12;
        chk("rst_we3", we3, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", lu_count, 0);
        chk("rst_ready", lu_ready, 1);
        rst = 1'b0;

        // Idle: no register reported busy
        for (int i = 0; i < 4; i++) begin
            chk_rs1 = 5'(i * 7); chk_rs2 = 5'(i * 3 + 1); chk_rd = 5'(31 - i);
            step();
            chk("idle_hazard", hazard, 0);
        end
        idle_inputs();

        // Pipe write goes out for exactly one cycle
        pipe_we = 1; pipe_rd = 5; pipe_wd = 32'hDEADBEEF;
        step();
        chk("pipe_we3", we3, 1);
        chk("pipe_a3", a3, 5);
        chk("pipe_wd3", wd3, 32'hDEADBEEF);
        idle_inputs();
        step();
        chk("pipe_we3_drop", we3, 0);

        // Issue to x7 then check decode hazard
        lu_issue = 1; lu_issue_rd = 7;
        step();
        idle_inputs();
        chk_rs1 = 7;
        #1;
        chk("issue_hazard", hazard, 1);
        step();

        // Deliver result for x7 with no pipe traffic
        idle_inputs();
        lu_valid = 1; lu_rd = 7; lu_data = 42;
        step();
        chk("lu_no_bypass", we3, 0);
        idle_inputs();
        chk_rs1 = 7;
        step();
        chk("lu_we3", we3, 1);
        chk("lu_a3", a3, 7);
        chk("lu_wd3", wd3, 42);
        chk("lu_busy7", busy[7], 0);
        #1;
        chk("lu_hazard_clear", hazard, 0);
        idle_inputs();
        step();

        // Three results under continuous pipe writes
        rds = '{10, 11, 12};
        for (int i = 0; i < 3; i++) dats[i] = $urandom;
        for (int i = 0; i < 3; i++) begin
            lu_issue = 1; lu_issue_rd = 5'(rds[i]);
            step();
        end
        idle_inputs();
        idx = 0;
        for (int c = 0; c < 40 && (idx < 3 || q_rd.size() > 0 || we3); c++) begin
            pipe_we = (c < 6); pipe_rd = 3; pipe_wd = $urandom;
            lu_valid = (idx < 3);
            lu_rd = 5'(rds[idx < 3 ? idx : 0]);
            lu_data = dats[idx < 3 ? idx : 0];
            rdy = (q_rd.size() < DEPTH);
            step();
            if (we3 && a3 != 3) begin
                got_rd.push_back(int'(a3));
                got_wd.push_back(wd3);
            end
            if (lu_valid && rdy) begin
                idx++;
                if (idx == 2 && c < 5) chk("ready_drop", lu_ready, 0);
            end
        end
        idle_inputs();
        chk("order_count", got_rd.size(), 3);
        for (int i = 0; i < 3 && i < got_rd.size(); i++) begin
            chk("order_rd", got_rd[i], rds[i]);
            chk("order_wd", got_wd[i], dats[i]);
        end

        // x0 issue and delivery are no-ops
        busy_before = m_busy;
        lu_issue = 1; lu_issue_rd = 0;
        step();
        idle_inputs();
        lu_valid = 1; lu_rd = 0; lu_data = 32'h1234_5678;
        step();
        chk("x0_ready", lu_ready, 1);
        idle_inputs();
        step();
        chk("x0_we3", we3, 0);
        chk("x0_busy", busy, busy_before);
        chk("x0_count", lu_count, 0);

        // Reset with two results buffered behind pipe traffic
        lu_issue = 1; lu_issue_rd = 20;
        step();
        lu_issue_rd = 21;
        step();
        idle_inputs();
        pipe_we = 1; pipe_rd = 4;
        lu_valid = 1; lu_rd = 20; lu_data = 32'hAAAA0001;
        step();
        lu_rd = 21; lu_data = 32'hAAAA0002;
        step();
        chk("prerst_count", lu_count, 2);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("mrst_count", lu_count, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_we3", we3, 0);
        #2;
        rst = 1'b0;
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("postrst_we3", we3, 0);
        end

        // Randomized traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            pipe_we = ($urandom_range(0, 2) == 0);
            pipe_rd = 5'($urandom);
            pipe_wd = $urandom;
            lu_issue = ($urandom_range(0, 2) == 0);
            lu_issue_rd = 5'($urandom);
            lu_valid = ($urandom_range(0, 1) == 0);
            lu_rd = 5'($urandom_range(0, 7));
            lu_data = $urandom;
            chk_rs1 = 5'($urandom);
            chk_rs2 = 5'($urandom);
            chk_rd = 5'($urandom);
            step();
        end
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
